// File: rtl/ram_fifo_ctrl.sv
// rtl/ram_fifo_ctrl.sv - FIFO controller around an external 2-cycle-latency RAM with a show-ahead output buffer
//
// Ports:
//   inclk, inrst_n            clock, asynchronous active-low reset
//   in_flush                  synchronous clear of all contents
//   in_wr_valid/in_wr_data    write request and word; out_wr_ready accepts it
//   out_rd_valid/out_rd_data  head word (show-ahead); in_rd_ready pops it
//   out_level, out_empty      total words held (RAM + in-flight + output buffer)
//   out_ram_*/in_ram_rddata   external RAM port; read data arrives 2 cycles after the address
module ram_fifo_ctrl #(
    parameter int p_addresswidth = 4,
    parameter int p_datawidth    = 16
) (
    input  logic                        inclk,
    input  logic                        inrst_n,
    input  logic                        in_flush,
    input  logic                        in_wr_valid,
    input  logic [p_datawidth-1:0]      in_wr_data,
    output logic                        out_wr_ready,
    output logic                        out_rd_valid,
    output logic [p_datawidth-1:0]      out_rd_data,
    input  logic                        in_rd_ready,
    output logic [p_addresswidth+1:0]   out_level,
    output logic                        out_empty,
    output logic                        out_ram_wren,
    output logic [p_addresswidth-1:0]   out_ram_wraddress,
    output logic [p_datawidth-1:0]      out_ram_wrdata,
    output logic [p_addresswidth-1:0]   out_ram_rdaddress,
    input  logic [p_datawidth-1:0]      in_ram_rddata
);

    localparam int c_pw = p_addresswidth + 1;
    localparam int c_lw = p_addresswidth + 2;

    logic [c_pw-1:0]                  wp, rp, ram_count, ram_count_next;
    logic                             v1, v2;
    logic [1:0]                       obuf_count, obuf_count_next, obuf_wr_idx;
    logic [2:0][p_datawidth-1:0]      obuf, obuf_next;
    logic [c_lw-1:0]                  level;
    logic [2:0]                       credit_used;
    logic                             wr_acc, pop, issue, wr_ready_next;

    assign wr_acc    = in_wr_valid && out_wr_ready && !in_flush;
    assign pop       = out_rd_valid && in_rd_ready && !in_flush;
    assign ram_count = wp - rp;

    // Output-buffer slots already spoken for, counting the pop happening now.
    // Keeping this below 3 guarantees every issued read has a slot when it lands.
    assign credit_used = {2'b00, v1} + {2'b00, v2} + {1'b0, obuf_count} - {2'b00, pop};

    // ram_count only reflects writes from earlier cycles, so a word being
    // written this cycle can never be the one read-issued this cycle.
    assign issue = !in_flush && (ram_count != '0) && (credit_used < 3'd3);

    assign ram_count_next = ram_count + c_pw'(wr_acc) - c_pw'(issue);
    // ram_count never exceeds the depth, so its MSB alone marks "full".
    assign wr_ready_next  = !in_flush && !ram_count_next[p_addresswidth];

    // Output buffer is a shift FIFO: entry 0 is always the head, so
    // out_rd_data comes straight from a register.
    always_comb begin
        obuf_next       = obuf;
        obuf_wr_idx     = obuf_count - {1'b0, pop};
        obuf_count_next = obuf_count + {1'b0, v2} - {1'b0, pop};
        if (pop) begin
            obuf_next[0] = obuf[1];
            obuf_next[1] = obuf[2];
        end
        if (v2) begin
            case (obuf_wr_idx)
                2'd0:    obuf_next[0] = in_ram_rddata;
                2'd1:    obuf_next[1] = in_ram_rddata;
                default: obuf_next[2] = in_ram_rddata;
            endcase
        end
    end

    always_ff @(posedge inclk or negedge inrst_n) begin
        if (!inrst_n) begin
            wp           <= '0;
            rp           <= '0;
            v1           <= 1'b0;
            v2           <= 1'b0;
            obuf         <= '0;
            obuf_count   <= '0;
            level        <= '0;
            out_wr_ready <= 1'b0;
        end else if (in_flush) begin
            wp           <= '0;
            rp           <= '0;
            v1           <= 1'b0;
            v2           <= 1'b0;
            obuf         <= '0;
            obuf_count   <= '0;
            level        <= '0;
            out_wr_ready <= 1'b0;
        end else begin
            wp           <= wp + c_pw'(wr_acc);
            rp           <= rp + c_pw'(issue);
            v1           <= issue;
            v2           <= v1;
            obuf         <= obuf_next;
            obuf_count   <= obuf_count_next;
            level        <= level + c_lw'(wr_acc) - c_lw'(pop);
            out_wr_ready <= wr_ready_next;
        end
    end

    assign out_rd_valid      = (obuf_count != 2'd0);
    assign out_rd_data       = obuf[0];
    assign out_level         = level;
    assign out_empty         = (level == '0);
    assign out_ram_wren      = wr_acc;
    assign out_ram_wraddress = wp[p_addresswidth-1:0];
    assign out_ram_wrdata    = in_wr_data;
    assign out_ram_rdaddress = rp[p_addresswidth-1:0];

endmodule

// File: doc/ram_fifo_ctrl.md
RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 Parameter p_addresswidth, default 4: RAM address bits; RAM depth is 2**p_addresswidth words.
REQ-002 Parameter p_datawidth, default 16: data word bits.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 inclk  in  1  sole clock; all state updates on rising edge.
REQ-005 inrst_n  in  1  asynchronous active-low reset.
REQ-006 in_flush  in  1  synchronous clear of all contents.
REQ-007 in_wr_valid  in  1  write request.
REQ-008 in_wr_data  in  p_datawidth  write word.
REQ-009 out_wr_ready  out  1  write accepted when in_wr_valid and out_wr_ready are both high.
REQ-010 out_rd_valid  out  1  out_rd_data holds the head word.
REQ-011 out_rd_data  out  p_datawidth  head word, show-ahead.
REQ-012 in_rd_ready  in  1  pop when out_rd_valid and in_rd_ready are both high.
REQ-013 out_level  out  p_addresswidth+2  total words held (RAM + in-flight + output buffer).
REQ-014 out_empty  out  1  out_level == 0.
REQ-015 out_ram_wren  out  1  RAM write strobe.
REQ-016 out_ram_wraddress  out  p_addresswidth  RAM write address.
REQ-017 out_ram_wrdata  out  p_datawidth  RAM write data.
REQ-018 out_ram_rdaddress  out  p_addresswidth  RAM read address.
REQ-019 in_ram_rddata  in  p_datawidth  RAM read data, valid exactly 2 cycles after the address is presented.

Function
REQ-020 The block SHALL keep a write pointer wp and a read-issue pointer rp, each p_addresswidth+1 bits and wrapping modulo 2**(p_addresswidth+1); the low p_addresswidth bits are the RAM address.
REQ-021 ram_count = wp - rp (modulo arithmetic); the RAM is full when ram_count == 2**p_addresswidth.
REQ-022 out_wr_ready SHALL be a register, updated each edge to 1 when (the next-cycle ram_count < 2**p_addresswidth and in_flush is low), else 0.
REQ-023 On an accepted write, out_ram_wren=1, out_ram_wraddress=wp[low], out_ram_wrdata=in_wr_data in the same cycle (combinational pass-through), and wp increments at the edge.
REQ-024 out_ram_rdaddress SHALL equal rp[low] at all times.
REQ-025 Read issue in cycle c when ram_count>0 and (inflight + obuf_count - pop_c) < 3; rp then increments at the edge.
REQ-026 A 2-stage valid shift register SHALL track issued reads; the stage-2 valid captures in_ram_rddata into the output buffer at the end of cycle c+2.
REQ-027 The output buffer SHALL be a 3-entry FIFO; out_rd_valid = (obuf_count>0), out_rd_data = obuf head, registered.
REQ-028 A word written in cycle t SHALL NOT be read-issued before cycle t+1, so a read never targets the address being written that cycle.
REQ-029 Latency: write accepted into an empty block in cycle t -> out_rd_valid=1 in cycle t+4.
REQ-030 Throughput: with in_wr_valid and in_rd_ready held high and out_rd_valid high, one write and one pop per cycle SHALL be sustained with no bubble.
REQ-031 Simultaneous write and pop SHALL leave out_level unchanged; the output buffer never overflows (credit rule of REQ-025).
REQ-032 out_level SHALL be updated at each edge as out_level + accepted_write - pop.
REQ-033 in_flush high in cycle f: at the edge, wp=rp=0, pipeline valids cleared, obuf emptied, out_level=0, out_rd_valid=0; a write or pop presented in cycle f is ignored; out_ram_wren=0 in cycle f.
REQ-034 When the block is empty, in_rd_ready SHALL have no effect; when out_wr_ready is low, in_wr_valid SHALL have no effect.

Reset
REQ-035 While inrst_n is low: wp=rp=0, pipeline valids=0, obuf empty, out_wr_ready=0, out_rd_valid=0, out_rd_data=0, out_level=0, out_empty=1, out_ram_wren=0.
REQ-036 out_wr_ready SHALL rise on the first clock edge after inrst_n deasserts.
REQ-037 Reset asserted mid-operation SHALL discard all contents and in-flight reads immediately and asynchronously.

Verification
REQ-038 Single word: write 0xA5A5 in cycle t -> out_rd_valid=1, out_rd_data=0xA5A5 in cycle t+4; pop -> out_empty=1 the next cycle.
REQ-039 Fill, p_addresswidth=4, in_rd_ready=0: 19 writes accepted (16 RAM + 3 obuf), out_wr_ready=0 afterwards, out_level=19; popping 19 words returns them in write order.
REQ-040 Streaming: 100 consecutive writes with in_rd_ready=1 -> after the initial fill, one pop per cycle, incrementing data sequence intact, no bubbles.
REQ-041 Wrap-around: 40 write/pop cycles on a 16-deep RAM -> pointers wrap, data order correct, out_level never exceeds 19.
REQ-042 Flush with 2 reads in flight -> the next cycle out_level=0, out_rd_valid=0, and no stale word appears afterwards; the next write returns its own data.
REQ-043 Reset asserted with 10 words held -> outputs take reset values immediately; out_wr_ready=1 one edge after release.
